tsm_prio_sched: RTL and testbench

//  Parametrised transmit scheduler for the traffic-generate path; next generation of the 8-queue TSM.

---
 rtl/tsm_pkg.sv | 22 ++
 rtl/tsm_prio_arb.sv | 51 +++++
 rtl/tsm_prio_sched.sv | 128 ++++++++++++
 tb/tb_tsm_prio_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tsm_pkg.sv
// Shared types and helpers for the TSM transmit scheduler.
package tsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_FIFO_CHK  = 3'd1,
        ST_ARB       = 3'd2,
        ST_GRANT     = 3'd3,
        ST_WAIT_FREE = 3'd4
    } tsm_state_e;

    // Ceiling log2 with a floor of 1 so that index/counter vectors never collapse to zero width.
    function automatic int tsm_clog2(input int n);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/tsm_prio_arb.sv
// Combinational one-hot picker for the TSM scheduler.
// Default build: strict priority, lowest set index of req wins.
// With TSM_RR_EN defined: rotating search starting at rr_ptr, wrapping modulo NUM_Q.
module tsm_prio_arb
    import tsm_pkg::*;
#(
    parameter int NUM_Q = 8,
    parameter int IDX_W = tsm_clog2(NUM_Q)
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NUM_Q-1:0] gnt,
    output logic [IDX_W-1:0] winner
);

    logic found;
    int   idx;

`ifndef TSM_RR_EN
    // The rotation pointer only matters in round-robin builds.
    logic rr_ptr_unused;
    assign rr_ptr_unused = ^rr_ptr;
`endif

    // Find the first requesting queue in search order and encode it one-hot.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
`ifdef TSM_RR_EN
        for (int k = 0; k < NUM_Q; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_Q;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
`else
        for (int i = 0; i < NUM_Q; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
`endif
        if (found) gnt[winner] = 1'b1;
    end

endmodule

// File: rtl/tsm_prio_sched.sv
// TSM transmit scheduler: picks one gate-valid queue per transmit slot and
// issues a one-cycle one-hot grant, with test-start gating, an outport-free
// watchdog, a busy flag and a wrapping grant counter.
// Optional feature macro: TSM_RR_EN (round-robin arbitration instead of strict priority).
module tsm_prio_sched
    import tsm_pkg::*;
#(
    parameter int NUM_Q       = 8,
    parameter int USEDW_W     = 7,
    parameter int FIFO_THRESH = 5,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_Q-1:0]   in_tsm_valid,
    input  logic               in_tsm_outport_free,
    input  logic               in_tsm_test_start,
    input  logic [USEDW_W-1:0] in_tsm_fifo_usedw,
    output logic [NUM_Q-1:0]   out_tsm_selected,
    output logic               out_tsm_busy,
    output logic               out_tsm_timeout,
    output logic [CNT_W-1:0]   out_tsm_grant_cnt
);

    localparam int IDX_W  = tsm_clog2(NUM_Q);
    localparam int WAIT_W = tsm_clog2((TIMEOUT_CYC > 1) ? TIMEOUT_CYC : 2);
    // The counter starts at 0 in the first WAIT_FREE cycle, so comparing the
    // pre-increment value against TIMEOUT_CYC-2 makes the pulse land exactly
    // TIMEOUT_CYC cycles after the GRANT cycle.
    localparam logic [WAIT_W-1:0] EXPIRE_AT = WAIT_W'((TIMEOUT_CYC >= 2) ? TIMEOUT_CYC - 2 : 0);

    tsm_state_e         state_q, state_d;
    logic [NUM_Q-1:0]   sel_q, sel_d;
    logic               to_q, to_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [NUM_Q-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_winner;
    logic               fifo_ok;
    logic               expire;

    tsm_prio_arb #(
        .NUM_Q (NUM_Q),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (in_tsm_valid),
        .rr_ptr (rr_q),
        .gnt    (arb_gnt),
        .winner (arb_winner)
    );

    assign fifo_ok = (in_tsm_fifo_usedw <= USEDW_W'(FIFO_THRESH));
    assign expire  = (TIMEOUT_CYC != 0) && (wait_q == EXPIRE_AT);

    // Next-state and next-output logic; dropping test_start overrides every other transition.
    always_comb begin
        state_d = state_q;
        sel_d   = '0;
        to_d    = 1'b0;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        if (!in_tsm_test_start) begin
            state_d = ST_IDLE;
            wait_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FIFO_CHK;
                ST_FIFO_CHK: begin
                    if (fifo_ok) state_d = ST_ARB;
                end
                ST_ARB: begin
                    if (|in_tsm_valid) begin
                        sel_d   = arb_gnt;
                        cnt_d   = cnt_q + CNT_W'(1);
                        rr_d    = (int'(arb_winner) == NUM_Q - 1) ? '0 : arb_winner + IDX_W'(1);
                        state_d = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state_d = ST_WAIT_FREE;
                    wait_d  = '0;
                end
                ST_WAIT_FREE: begin
                    if (in_tsm_outport_free) begin
                        state_d = ST_FIFO_CHK;
                        wait_d  = '0;
                    end else if (expire) begin
                        to_d    = 1'b1;
                        state_d = ST_FIFO_CHK;
                        wait_d  = '0;
                    end else begin
                        wait_d  = wait_q + WAIT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            to_q    <= 1'b0;
            wait_q  <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state_q <= state_d;
            sel_q   <= sel_d;
            to_q    <= to_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign out_tsm_selected  = sel_q;
    assign out_tsm_timeout   = to_q;
    assign out_tsm_grant_cnt = cnt_q;
    assign out_tsm_busy      = (state_q == ST_GRANT) || (state_q == ST_WAIT_FREE);

endmodule

// File: tb/tb_tsm_prio_sched.sv
// Scoreboard bench for tsm_prio_sched: a slot-level reference model predicts
// grants, busy, timeout and grant count; a negedge monitor compares.
module tb_tsm_prio_sched;

    localparam int NUM_Q       = 8;
    localparam int USEDW_W     = 7;
    localparam int FIFO_THRESH = 5;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 4;

    localparam int P_IDLE  = 0;
    localparam int P_FIFO  = 1;
    localparam int P_ARB   = 2;
    localparam int P_GRANT = 3;
    localparam int P_WAIT  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_Q-1:0]   in_tsm_valid;
    logic               in_tsm_outport_free;
    logic               in_tsm_test_start;
    logic [USEDW_W-1:0] in_tsm_fifo_usedw;
    logic [NUM_Q-1:0]   out_tsm_selected;
    logic               out_tsm_busy;
    logic               out_tsm_timeout;
    logic [CNT_W-1:0]   out_tsm_grant_cnt;

    always #5 clk = ~clk;

    tsm_prio_sched #(
        .NUM_Q       (NUM_Q),
        .USEDW_W     (USEDW_W),
        .FIFO_THRESH (FIFO_THRESH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_tsm_valid        (in_tsm_valid),
        .in_tsm_outport_free (in_tsm_outport_free),
        .in_tsm_test_start   (in_tsm_test_start),
        .in_tsm_fifo_usedw   (in_tsm_fifo_usedw),
        .out_tsm_selected    (out_tsm_selected),
        .out_tsm_busy        (out_tsm_busy),
        .out_tsm_timeout     (out_tsm_timeout),
        .out_tsm_grant_cnt   (out_tsm_grant_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: committed view of the current cycle and the prediction for the next.
    int m_phase, m_waited, m_cnt, m_rr;
    int n_phase, n_waited, n_cnt, n_rr, n_timeout, n_grant;
    bit exp_busy, exp_timeout, exp_grant_now;
    int exp_cnt;
    logic [NUM_Q-1:0] grant_q[$];
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner by the arbitration rule of the build.
    function automatic int pick(input logic [NUM_Q-1:0] v, input int rr);
        int idx;
`ifdef TSM_RR_EN
        for (int k = 0; k < NUM_Q; k++) begin
            idx = (rr + k) % NUM_Q;
            if (v[idx]) return idx;
        end
`else
        idx = rr;
        for (int i = 0; i < NUM_Q; i++) if (v[i]) return i;
`endif
        return idx;
    endfunction

    task automatic model_step();
        int w;
        n_phase = m_phase; n_waited = m_waited; n_cnt = m_cnt; n_rr = m_rr;
        n_timeout = 0; n_grant = 0;
        if (!in_tsm_test_start) begin
            n_phase = P_IDLE; n_waited = 0;
        end else begin
            case (m_phase)
                P_IDLE: n_phase = P_FIFO;
                P_FIFO: if (int'(in_tsm_fifo_usedw) <= FIFO_THRESH) n_phase = P_ARB;
                P_ARB: if (in_tsm_valid != 0) begin
                    w       = pick(in_tsm_valid, m_rr);
                    n_grant = 1 << w;
                    n_cnt   = (m_cnt + 1) % (1 << CNT_W);
                    n_rr    = (w + 1) % NUM_Q;
                    n_phase = P_GRANT;
                end
                P_GRANT: begin n_phase = P_WAIT; n_waited = 0; end
                P_WAIT: begin
                    n_waited = m_waited + 1;
                    if (in_tsm_outport_free) n_phase = P_FIFO;
                    else if (n_waited == TIMEOUT_CYC - 1) begin n_timeout = 1; n_phase = P_FIFO; end
                end
                default: n_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic commit();
        m_phase = n_phase; m_waited = n_waited; m_cnt = n_cnt; m_rr = n_rr;
        exp_busy      = (m_phase == P_GRANT) || (m_phase == P_WAIT);
        exp_timeout   = (n_timeout != 0);
        exp_cnt       = m_cnt;
        exp_grant_now = (n_grant != 0);
        if (n_grant != 0) grant_q.push_back(NUM_Q'(n_grant));
    endtask

    // Drive one cycle of inputs, predict, then advance past the edge.
    task automatic cycle(input bit ts, input bit fr, input int uw, input logic [NUM_Q-1:0] v);
        in_tsm_test_start   = ts;
        in_tsm_outport_free = fr;
        in_tsm_fifo_usedw   = USEDW_W'(uw);
        in_tsm_valid        = v;
        model_step();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic wait_phase(input int ph, input logic [NUM_Q-1:0] v);
        int n;
        n = 0;
        while (m_phase != ph && n < 100) begin
            cycle(1'b1, 1'b0, 0, v);
            n++;
        end
        check("wait_phase_bound", 32'(m_phase == ph), 32'd1);
    endtask

    // Monitor: per-cycle status checks, and a scoreboard pop whenever a grant is shown or due.
    initial begin
        logic [NUM_Q-1:0] g;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", 32'(out_tsm_busy), 32'(exp_busy));
                check("timeout", 32'(out_tsm_timeout), 32'(exp_timeout));
                check("grant_cnt", 32'(out_tsm_grant_cnt), 32'(exp_cnt));
                if (out_tsm_selected != 0 || exp_grant_now) begin
                    if (grant_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL selected: got %0h expected no grant at %0t", out_tsm_selected, $time);
                    end else begin
                        g = grant_q.pop_front();
                        check("selected", 32'(out_tsm_selected), 32'(g));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_tsm_test_start = 1'b0; in_tsm_outport_free = 1'b0;
        in_tsm_fifo_usedw = '0;   in_tsm_valid = '0;
        m_phase = P_IDLE; m_waited = 0; m_cnt = 0; m_rr = 0;
        exp_busy = 0; exp_timeout = 0; exp_cnt = 0; exp_grant_now = 0;
        repeat (2) @(negedge clk);
        check("rst_selected", 32'(out_tsm_selected), 32'd0);
        check("rst_busy", 32'(out_tsm_busy), 32'd0);
        check("rst_timeout", 32'(out_tsm_timeout), 32'd0);
        check("rst_grant_cnt", 32'(out_tsm_grant_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // First slot after start: valid 0C grants queue 2 (strict) or first set from ptr 0 (rr).
        repeat (6) cycle(1'b1, 1'b0, 0, 8'h0C);
        cycle(1'b1, 1'b1, 0, 8'h0C);

        // FIFO too full blocks arbitration until usedw drops to threshold.
        repeat (5) cycle(1'b1, 1'b0, 6, 8'hFF);
        repeat (4) cycle(1'b1, 1'b0, 5, 8'hFF);

        // Watchdog expiry with outport_free held low.
        repeat (20) cycle(1'b1, 1'b0, 0, 8'h22);

        // outport_free lands on the expiry cycle: no timeout pulse.
        wait_phase(P_GRANT, 8'h10);
        repeat (TIMEOUT_CYC - 1) cycle(1'b1, 1'b0, 0, 8'h10);
        cycle(1'b1, 1'b1, 0, 8'h10);
        repeat (3) cycle(1'b1, 1'b0, 9, 8'h00);

        // test_start drops in WAIT_FREE: back to idle, counter held, no grants.
        wait_phase(P_WAIT, 8'h40);
        repeat (4) cycle(1'b0, 1'b0, 0, 8'hFF);
        cycle(1'b0, 1'b1, 0, 8'hFF);
        repeat (6) cycle(1'b1, 1'b0, 0, 8'h08);
        cycle(1'b1, 1'b1, 0, 8'h08);

        // Valid 81 with free every cycle: alternates under rr, always 01 otherwise.
        repeat (24) cycle(1'b1, 1'b1, 0, 8'h81);

        // Randomised traffic; many grants so the 4-bit counter wraps repeatedly.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 97),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 9)),
                  ($urandom_range(0, 4) == 0) ? 8'h00 : NUM_Q'($urandom));
        end

        repeat (4) cycle(1'b0, 1'b0, 0, 8'h00);
        check("scoreboard_empty", 32'(grant_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
